// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller: start/data/stop sequencing on the oversampling clock.
// Optional even-parity bit between data and stop is enabled with `define UART_PARITY_EN.
module uart_rx_ctrl #(
  parameter int DATA_BITS = 8,
  parameter int OSR       = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 busy,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);
  localparam int PW = $clog2(OSR);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [PW-1:0] CNT_HALF = PW'(OSR/2 - 1);
  localparam logic [PW-1:0] CNT_LAST = PW'(OSR - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  state_t               state;
  logic                 rx_m, rx_s, rx_p;
  logic [PW-1:0]        cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 deliver;
  logic                 accept;

  assign accept = valid & ready;

`ifdef UART_PARITY_EN
  logic par_bad;
`else
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m      <= 1'b1;
      rx_s      <= 1'b1;
      rx_p      <= 1'b1;
      state     <= S_IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      deliver   <= 1'b0;
      data      <= '0;
      valid     <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_PARITY_EN
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      rx_m      <= rx;
      rx_s      <= rx_m;
      rx_p      <= rx_s;
      cnt       <= cnt + 1'b1;
      deliver   <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_PARITY_EN
      parity_err <= 1'b0;
`endif

      case (state)
        S_IDLE: begin
          if (rx_p && !rx_s) begin
            state <= S_START;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end

        // Mid-start-bit check rejects glitches shorter than half a bit.
        S_START: begin
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            if (!rx_s) begin
              state   <= S_DATA;
              bit_cnt <= '0;
`ifdef UART_PARITY_EN
              par_bad <= 1'b0;
`endif
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end
        end

        S_DATA: begin
          if (cnt == CNT_LAST) begin
            shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == BIT_LAST) begin
              cnt   <= '0;
`ifdef UART_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end
          end
        end

`ifdef UART_PARITY_EN
        S_PARITY: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= S_STOP;
            if ((^shreg) ^ rx_s) begin
              par_bad    <= 1'b1;
              parity_err <= 1'b1;
            end
          end
        end
`endif

        S_STOP: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              state <= S_IDLE;
              busy  <= 1'b0;
`ifdef UART_PARITY_EN
              deliver <= ~par_bad;
`else
              deliver <= 1'b1;
`endif
            end else begin
              state     <= S_BREAK;
              frame_err <= 1'b1;
            end
          end
        end

        S_BREAK: begin
          if (rx_s) begin
            state <= S_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase

      // A delivery coinciding with a handshake replaces the consumed byte.
      if (deliver) begin
        if (!valid || accept) begin
          data  <= shreg;
          valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (accept) begin
        valid <= 1'b0;
      end
      if (accept) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed scenarios plus randomized frames
// compared against a frame-level expectation queue.
module tb_uart_rx_ctrl;
  localparam int DB  = 8;
  localparam int OSR = 16;
`ifdef UART_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int LAT = 2 + OSR/2 + OSR*(DB + 1 + PB) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          rx = 1'b1;
  logic          ready = 1'b0;
  logic [DB-1:0] data;
  logic          valid, busy, frame_err, parity_err, overrun;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int rise_cyc = 0;
  int n_valid = 0, n_ferr = 0, n_perr = 0, n_busy = 0;
  logic valid_d = 1'b0;
  logic [DB-1:0] got[$];

  uart_rx_ctrl #(.DATA_BITS(DB), .OSR(OSR)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .data(data), .valid(valid), .ready(ready),
    .busy(busy), .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid && !valid_d) rise_cyc <= cyc;
    valid_d <= valid;
    if (valid) n_valid <= n_valid + 1;
    if (frame_err) n_ferr <= n_ferr + 1;
    if (parity_err) n_perr <= n_perr + 1;
    if (busy) n_busy <= n_busy + 1;
    if (valid && ready) got.push_back(data);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    tick(n * OSR);
  endtask

  task automatic send_frame(input logic [DB-1:0] b, input logic par, input logic stop);
    rx = 1'b0;
    start_cyc = cyc;
    tick(OSR);
    for (int i = 0; i < DB; i++) begin
      rx = b[i];
      tick(OSR);
    end
    if (PB != 0) begin
      rx = par;
      tick(OSR);
    end
    rx = stop;
    tick(OSR);
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    #20;
    checks++; if (data !== '0)        begin errors++; $display("FAIL reset_data got %0h exp 0", data); end
    checks++; if (valid !== 1'b0)     begin errors++; $display("FAIL reset_valid got %0b exp 0", valid); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %0b exp 0", frame_err); end
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_parity_err got %0b exp 0", parity_err); end
    checks++; if (overrun !== 1'b0)   begin errors++; $display("FAIL reset_overrun got %0b exp 0", overrun); end
    @(posedge clk); #1 rst_n = 1'b1;
    tick(4);
  endtask

  task automatic test_basic;
    int v0, f0, p0, g0, lat;
    logic [DB-1:0] b, d0;
    b = 8'hA5;
    ready = 1'b1;
    v0 = n_valid; f0 = n_ferr; p0 = n_perr; g0 = got.size();
    send_frame(b, ^b, 1'b1);
    idle_bits(2);
    lat = rise_cyc - start_cyc - 1;
    d0 = (got.size() > g0) ? got[g0] : '0;
    checks++; if (got.size() - g0 !== 1) begin errors++; $display("FAIL basic_count got %0d exp 1", got.size() - g0); end
    checks++; if (d0 !== b)             begin errors++; $display("FAIL basic_data got %0h exp %0h", d0, b); end
    checks++; if (n_valid - v0 !== 1)   begin errors++; $display("FAIL basic_valid_cycles got %0d exp 1", n_valid - v0); end
    checks++; if (lat !== LAT)          begin errors++; $display("FAIL basic_latency got %0d exp %0d", lat, LAT); end
    checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL basic_busy got %0b exp 0", busy); end
    checks++; if (n_ferr - f0 !== 0 || n_perr - p0 !== 0)
      begin errors++; $display("FAIL basic_flags got ferr %0d perr %0d exp 0 0", n_ferr - f0, n_perr - p0); end
  endtask

  task automatic test_back_to_back;
    int g0;
    logic [DB-1:0] a, b, d0;
    a = 8'h3C; b = 8'h81;
    ready = 1'b0;
    g0 = got.size();
    send_frame(a, ^a, 1'b1);
    idle_bits(2);
    send_frame(b, ^b, 1'b1);
    idle_bits(2);
    checks++; if (data !== a)       begin errors++; $display("FAIL b2b_data got %0h exp %0h", data, a); end
    checks++; if (valid !== 1'b1)   begin errors++; $display("FAIL b2b_valid got %0b exp 1", valid); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL b2b_overrun got %0b exp 1", overrun); end
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    d0 = (got.size() > g0) ? got[g0] : '0;
    checks++; if (valid !== 1'b0)   begin errors++; $display("FAIL b2b_valid_clr got %0b exp 0", valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun_clr got %0b exp 0", overrun); end
    checks++; if (got.size() - g0 !== 1 || d0 !== a)
      begin errors++; $display("FAIL b2b_consumed got n=%0d d=%0h exp n=1 d=%0h", got.size() - g0, d0, a); end
    ready = 1'b1;
  endtask

  task automatic test_glitch;
    int v0, f0, p0, b0;
    v0 = n_valid; f0 = n_ferr; p0 = n_perr; b0 = n_busy;
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(3 * OSR);
    checks++; if (n_valid - v0 !== 0) begin errors++; $display("FAIL glitch_valid got %0d exp 0", n_valid - v0); end
    checks++; if (n_ferr - f0 !== 0 || n_perr - p0 !== 0)
      begin errors++; $display("FAIL glitch_flags got ferr %0d perr %0d exp 0 0", n_ferr - f0, n_perr - p0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy got %0b exp 0", busy); end
    checks++; if (n_busy - b0 !== OSR/2)
      begin errors++; $display("FAIL glitch_busy_cycles got %0d exp %0d", n_busy - b0, OSR/2); end
  endtask

  task automatic test_break;
    int v0, f0;
    logic [DB-1:0] b;
    b = 8'h55;
    ready = 1'b1;
    v0 = n_valid; f0 = n_ferr;
    send_frame(b, ^b, 1'b0);
    rx = 1'b0;
    tick(50 * OSR);
    checks++; if (busy !== 1'b1)      begin errors++; $display("FAIL break_busy_low got %0b exp 1", busy); end
    checks++; if (n_ferr - f0 !== 1)  begin errors++; $display("FAIL break_ferr got %0d exp 1", n_ferr - f0); end
    checks++; if (n_valid - v0 !== 0) begin errors++; $display("FAIL break_valid got %0d exp 0", n_valid - v0); end
    rx = 1'b1;
    tick(8);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL break_busy_release got %0b exp 0", busy); end
    idle_bits(4);
    checks++; if (n_ferr - f0 !== 1 || n_valid - v0 !== 0)
      begin errors++; $display("FAIL break_after got ferr %0d valid %0d exp 1 0", n_ferr - f0, n_valid - v0); end
  endtask

  task automatic test_reset_midframe;
    int v0, f0, g0;
    logic [DB-1:0] b, d0;
    ready = 1'b1;
    v0 = n_valid; f0 = n_ferr;
    rx = 1'b0;
    tick(OSR);
    rx = 1'b1;
    tick(4 * OSR);
    rst_n = 1'b0;
    tick(2);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %0b exp 0", busy); end
    rst_n = 1'b1;
    tick(5 * OSR);
    checks++; if (n_valid - v0 !== 0 || n_ferr - f0 !== 0)
      begin errors++; $display("FAIL midrst_no_output got valid %0d ferr %0d exp 0 0", n_valid - v0, n_ferr - f0); end
    b = 8'h12;
    g0 = got.size();
    send_frame(b, ^b, 1'b1);
    idle_bits(2);
    d0 = (got.size() > g0) ? got[g0] : '0;
    checks++; if (got.size() - g0 !== 1 || d0 !== b)
      begin errors++; $display("FAIL midrst_next got n=%0d d=%0h exp n=1 d=%0h", got.size() - g0, d0, b); end
  endtask

  task automatic test_random;
    logic [DB-1:0] exp_q[$];
    logic [DB-1:0] b;
    logic stop_ok, par_ok;
    int g0, f0, p0, exp_f, exp_p, n_got;
    ready = 1'b1;
    g0 = got.size(); f0 = n_ferr; p0 = n_perr;
    exp_f = 0; exp_p = 0;
    for (int k = 0; k < 24; k++) begin
      b = DB'($urandom);
      stop_ok = ($urandom_range(0, 4) != 0);
      par_ok = (PB == 0) || ($urandom_range(0, 4) != 0);
      send_frame(b, par_ok ? ^b : ~^b, stop_ok);
      idle_bits($urandom_range(1, 3));
      if (stop_ok && par_ok) exp_q.push_back(b);
      if (!stop_ok) exp_f++;
      if (!par_ok) exp_p++;
    end
    n_got = got.size() - g0;
    checks++; if (n_got !== exp_q.size())
      begin errors++; $display("FAIL rand_count got %0d exp %0d", n_got, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < n_got; i++) begin
      checks++; if (got[g0 + i] !== exp_q[i])
        begin errors++; $display("FAIL rand_data[%0d] got %0h exp %0h", i, got[g0 + i], exp_q[i]); end
    end
    checks++; if (n_ferr - f0 !== exp_f) begin errors++; $display("FAIL rand_ferr got %0d exp %0d", n_ferr - f0, exp_f); end
    checks++; if (n_perr - p0 !== exp_p) begin errors++; $display("FAIL rand_perr got %0d exp %0d", n_perr - p0, exp_p); end
  endtask

`ifdef UART_PARITY_EN
  task automatic test_parity;
    int v0, f0, p0, g0;
    logic [DB-1:0] b, d0;
    b = 8'h07;
    ready = 1'b1;
    v0 = n_valid; f0 = n_ferr; p0 = n_perr; g0 = got.size();
    send_frame(b, 1'b1, 1'b1);
    idle_bits(2);
    d0 = (got.size() > g0) ? got[g0] : '0;
    checks++; if (n_valid - v0 !== 1 || d0 !== b)
      begin errors++; $display("FAIL par_good got valid %0d d=%0h exp 1 %0h", n_valid - v0, d0, b); end
    checks++; if (n_perr - p0 !== 0 || n_ferr - f0 !== 0)
      begin errors++; $display("FAIL par_good_flags got perr %0d ferr %0d exp 0 0", n_perr - p0, n_ferr - f0); end
    v0 = n_valid; p0 = n_perr; f0 = n_ferr;
    send_frame(b, 1'b0, 1'b1);
    idle_bits(2);
    checks++; if (n_perr - p0 !== 1)  begin errors++; $display("FAIL par_bad_perr got %0d exp 1", n_perr - p0); end
    checks++; if (n_valid - v0 !== 0) begin errors++; $display("FAIL par_bad_valid got %0d exp 0", n_valid - v0); end
    checks++; if (n_ferr - f0 !== 0)  begin errors++; $display("FAIL par_bad_ferr got %0d exp 0", n_ferr - f0); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_glitch();
    test_break();
    test_reset_midframe();
`ifdef UART_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
